motor_ramp_sequencer: RTL and testbench

MOTOR_RAMP_SEQUENCER -- requirements
Module: motor_ramp_sequencer

---
 rtl/motor_pkg.sv | 13 +
 rtl/ramp_channel.sv | 88 ++++++++
 rtl/motor_ramp_sequencer.sv | 114 +++++++++++
 tb/tb_motor_ramp_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the two-channel motor ramp sequencer.
package motor_pkg;

    localparam int unsigned MAG_W   = 7;
    localparam int unsigned DIR_BIT = 7;
    localparam int unsigned MAG_MSB = 6;

    typedef enum logic {
        StRamp,
        StDead
    } ch_state_e;

endpackage

// File: rtl/ramp_channel.sv
// One motor channel: ramps duty toward its target, inserting a zero-duty dead
// interval before any direction reversal. All updates happen on tick_i only.
module ramp_channel
    import motor_pkg::*;
#(
    parameter int unsigned STEP       = 4,
    parameter int unsigned DEAD_TICKS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             tdir_i,
    input  logic [MAG_W-1:0] tmag_i,
    output logic             dir_o,
    output logic [MAG_W-1:0] duty_o,
    output logic             busy_o
);

    localparam int unsigned DeadW = ($clog2(DEAD_TICKS + 1) > 0) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam logic [MAG_W:0] StepW = (MAG_W + 1)'(STEP);

    ch_state_e        state_q, state_d;
    logic             dir_q, dir_d;
    logic [MAG_W-1:0] duty_q, duty_d;
    logic [DeadW-1:0] dead_q, dead_d;

    // One extra bit so the step arithmetic cannot wrap.
    logic [MAG_W:0] duty_x, tmag_x;
    assign duty_x = {1'b0, duty_q};
    assign tmag_x = {1'b0, tmag_i};

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        duty_d  = duty_q;
        dead_d  = dead_q;
        if (tick_i) begin
            unique case (state_q)
                StRamp: begin
                    if (tmag_i != '0 && tdir_i != dir_q) begin
                        if (duty_q == '0) begin
                            state_d = StDead;
                            dead_d  = DeadW'(DEAD_TICKS);
                        end else if (duty_x > StepW) begin
                            duty_d = MAG_W'(duty_x - StepW);
                        end else begin
                            duty_d = '0;
                        end
                    end else if (duty_x < tmag_x) begin
                        duty_d = (tmag_x - duty_x > StepW) ? MAG_W'(duty_x + StepW) : tmag_i;
                    end else if (duty_x > tmag_x) begin
                        duty_d = (duty_x - tmag_x > StepW) ? MAG_W'(duty_x - StepW) : tmag_i;
                    end
                end
                StDead: begin
                    // Direction is resolved from the latest target only as DEAD ends.
                    if (dead_q <= DeadW'(1)) begin
                        dead_d  = '0;
                        dir_d   = tdir_i;
                        state_d = StRamp;
                    end else begin
                        dead_d = dead_q - DeadW'(1);
                    end
                end
                default: state_d = StRamp;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRamp;
            dir_q   <= 1'b0;
            duty_q  <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
        end
    end

    assign dir_o  = dir_q;
    assign duty_o = duty_q;
    assign busy_o = (state_q == StDead) || (duty_q != tmag_i);

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Two-channel motor ramp sequencer: synchronizes the SPI load strobe, captures
// commands, generates the ramp tick and enforces the command watchdog.
module motor_ramp_sequencer
    import motor_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 250,
    parameter int unsigned STEP       = 4,
    parameter int unsigned DEAD_TICKS = 8,
    parameter int unsigned WDOG_TICKS = 500
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [7:0]       cmd1_i,
    input  logic [7:0]       cmd2_i,
    output logic             dir1_o,
    output logic [MAG_W-1:0] duty1_o,
    output logic             dir2_o,
    output logic [MAG_W-1:0] duty2_o,
    output logic             stopped_o,
    output logic             busy_o
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned WdW   = $clog2(WDOG_TICKS + 1);

    // [0],[1] form the synchronizer; [2] holds the previous synchronized value.
    logic [2:0]             load_sync_q;
    logic                   load_fall;
    logic                   cap_q;
    logic [TickW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                   tick;
    logic [WdW-1:0]         wdog_q, wdog_d;
    logic                   stopped_q, stopped_d;
    logic [1:0]             tdir_q, tdir_d;
    logic [1:0][MAG_W-1:0]  tmag_q, tmag_d;
    logic                   busy1, busy2;

    assign load_fall = load_sync_q[2] & ~load_sync_q[1];
    assign tick      = (tick_cnt_q == TickW'(TICK_DIV - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
        wdog_d     = wdog_q;
        stopped_d  = stopped_q;
        tdir_d     = tdir_q;
        tmag_d     = tmag_q;
        // A capture outranks a watchdog expiry in the same cycle.
        if (cap_q) begin
            tdir_d    = {cmd2_i[DIR_BIT], cmd1_i[DIR_BIT]};
            tmag_d    = {cmd2_i[MAG_MSB:0], cmd1_i[MAG_MSB:0]};
            wdog_d    = '0;
            stopped_d = 1'b0;
        end else if (tick && wdog_q != WdW'(WDOG_TICKS)) begin
            wdog_d = wdog_q + WdW'(1);
            if (wdog_q == WdW'(WDOG_TICKS - 1)) begin
                stopped_d = 1'b1;
                tmag_d    = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            load_sync_q <= '0;
            cap_q       <= 1'b0;
            tick_cnt_q  <= '0;
            wdog_q      <= '0;
            stopped_q   <= 1'b1;
            tdir_q      <= '0;
            tmag_q      <= '0;
        end else begin
            load_sync_q <= {load_sync_q[1:0], load_i};
            cap_q       <= load_fall;
            tick_cnt_q  <= tick_cnt_d;
            wdog_q      <= wdog_d;
            stopped_q   <= stopped_d;
            tdir_q      <= tdir_d;
            tmag_q      <= tmag_d;
        end
    end

    ramp_channel #(
        .STEP       (STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_ch1 (
        .clk_i  (clk_i),
        .rst_i  (reset_i),
        .tick_i (tick),
        .tdir_i (tdir_q[0]),
        .tmag_i (tmag_q[0]),
        .dir_o  (dir1_o),
        .duty_o (duty1_o),
        .busy_o (busy1)
    );

    ramp_channel #(
        .STEP       (STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_ch2 (
        .clk_i  (clk_i),
        .rst_i  (reset_i),
        .tick_i (tick),
        .tdir_i (tdir_q[1]),
        .tmag_i (tmag_q[1]),
        .dir_o  (dir2_o),
        .duty_o (duty2_o),
        .busy_o (busy2)
    );

    assign stopped_o = stopped_q;
    assign busy_o    = busy1 | busy2;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Scoreboard bench: a per-tick reference model pushes expected outputs, a
// monitor pops and compares them against the sequencer on the following negedge.
module tb_motor_ramp_sequencer;

    localparam int TD = 4;
    localparam int ST = 8;
    localparam int DT = 2;
    localparam int WD = 20;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       load;
    logic [7:0] cmd1, cmd2;
    logic       dir1, dir2, stopped, busy;
    logic [6:0] duty1, duty2;

    always #5 clk = ~clk;

    motor_ramp_sequencer #(
        .TICK_DIV   (TD),
        .STEP       (ST),
        .DEAD_TICKS (DT),
        .WDOG_TICKS (WD)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (load),
        .cmd1_i    (cmd1),
        .cmd2_i    (cmd2),
        .dir1_o    (dir1),
        .duty1_o   (duty1),
        .dir2_o    (dir2),
        .duty2_o   (duty2),
        .stopped_o (stopped),
        .busy_o    (busy)
    );

    typedef struct {
        int dir1;
        int duty1;
        int dir2;
        int duty2;
        int stopped;
        int busy;
    } exp_t;

    exp_t exp_q[$];

    int m_tdir[2], m_tmag[2], m_dir[2], m_duty[2], m_dead[2], m_left[2];
    int m_w, m_stop;
    int cyc;
    int n_cmp = 0;
    int n_bad = 0;
    int n_smp = 0;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_tdir[c] = 0; m_tmag[c] = 0; m_dir[c] = 0;
            m_duty[c] = 0; m_dead[c] = 0; m_left[c] = 0;
        end
        m_w    = 0;
        m_stop = 1;
    endfunction

    function automatic void model_capture(input logic [7:0] c1, input logic [7:0] c2);
        m_tdir[0] = int'(c1) / 128; m_tmag[0] = int'(c1) % 128;
        m_tdir[1] = int'(c2) / 128; m_tmag[1] = int'(c2) % 128;
        m_w    = 0;
        m_stop = 0;
    endfunction

    function automatic void model_tick();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (m_dead[c] != 0) begin
                m_left[c] = m_left[c] - 1;
                if (m_left[c] <= 0) begin
                    m_dead[c] = 0;
                    m_dir[c]  = m_tdir[c];
                end
            end else if (m_tmag[c] != 0 && m_tdir[c] != m_dir[c]) begin
                if (m_duty[c] == 0) begin
                    m_dead[c] = 1;
                    m_left[c] = DT;
                end else begin
                    m_duty[c] = (m_duty[c] - ST < 0) ? 0 : m_duty[c] - ST;
                end
            end else if (m_duty[c] < m_tmag[c]) begin
                m_duty[c] = (m_duty[c] + ST > m_tmag[c]) ? m_tmag[c] : m_duty[c] + ST;
            end else begin
                m_duty[c] = (m_duty[c] - ST < m_tmag[c]) ? m_tmag[c] : m_duty[c] - ST;
            end
        end
        if (m_w < WD) begin
            m_w = m_w + 1;
            if (m_w == WD) begin
                m_stop    = 1;
                m_tmag[0] = 0;
                m_tmag[1] = 0;
            end
        end
        e.dir1    = m_dir[0];
        e.duty1   = m_duty[0];
        e.dir2    = m_dir[1];
        e.duty2   = m_duty[1];
        e.stopped = m_stop;
        e.busy    = (m_dead[0] != 0 || m_dead[1] != 0 ||
                     m_duty[0] != m_tmag[0] || m_duty[1] != m_tmag[1]) ? 1 : 0;
        exp_q.push_back(e);
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input int req);
        n_cmp++;
        if (act !== 32'(req)) begin
            n_bad++;
            $display("FAIL %s (sample %0d, t=%0t): got %0d, required %0d",
                     name, n_smp, $time, act, req);
        end
    endfunction

    // Tick bookkeeping: the DUT's divider restarts at reset release.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc = 0;
            end else begin
                cyc++;
                if (cyc % TD == 0) model_tick();
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_smp++;
                check("dir1",    32'(dir1),    e.dir1);
                check("duty1",   32'(duty1),   e.duty1);
                check("dir2",    32'(dir2),    e.dir2);
                check("duty2",   32'(duty2),   e.duty2);
                check("stopped", 32'(stopped), e.stopped);
                check("busy",    32'(busy),    e.busy);
            end
        end
    end

    task automatic check_reset_state();
        check("rst_dir1",    32'(dir1),    0);
        check("rst_duty1",   32'(duty1),   0);
        check("rst_dir2",    32'(dir2),    0);
        check("rst_duty2",   32'(duty2),   0);
        check("rst_stopped", 32'(stopped), 1);
        check("rst_busy",    32'(busy),    0);
    endtask

    // Load falls just after a tick+1 edge, so the capture lands between ticks.
    task automatic capture(input logic [7:0] c1, input logic [7:0] c2);
        @(negedge clk);
        while (cyc % TD != 2) @(negedge clk);
        load = 1'b1;
        cmd1 = c1;
        cmd2 = c2;
        repeat (3) @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        model_capture(c1, c2);
    endtask

    task automatic run_ticks(input int k);
        repeat (k * TD) @(negedge clk);
    endtask

    initial begin
        load = 1'b0;
        cmd1 = 8'h00;
        cmd2 = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_reset_state();
        @(negedge clk);
        reset = 1'b0;

        capture(8'h28, 8'h00); run_ticks(7);
        capture(8'h94, 8'h00); run_ticks(12);
        capture(8'h80, 8'h00); run_ticks(4);
        capture(8'h85, 8'h00); run_ticks(2);
        capture(8'h28, 8'h00); run_ticks(6);
        run_ticks(26);
        capture(8'h28, 8'h00); run_ticks(6);
        capture(8'h94, 8'h00); run_ticks(6);
        capture(8'h10, 8'h00); run_ticks(8);

        // Reset while channel 1 is in DEAD and channel 2 is ramping.
        capture(8'h90, 8'h7f); run_ticks(3);
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1 check_reset_state();
        @(negedge clk);
        reset = 1'b0;
        capture(8'h20, 8'h20); run_ticks(6);

        for (int i = 0; i < 40; i++) begin
            capture(8'($urandom), 8'($urandom));
            run_ticks($urandom_range(0, 8));
            if ($urandom_range(0, 9) == 0) run_ticks(22);
        end
        run_ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
